// File: rtl/alpharetz_spi_pkg.sv
// Shared word width and FSM state encoding for the alpharetz SPI peripheral.
package alpharetz_spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_periph_state_t;

endpackage

// File: rtl/alpharetz_spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin with rise/fall strobes on the synchronized level.
module alpharetz_spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q      = sync_q[SYNC_STAGES-1];
  assign rise_c = q & ~prev_q;
  assign fall_c = ~q & prev_q;

endmodule

// File: rtl/alpharetz_spi_peripheral.sv
// SPI mode-0 target endpoint, MSB first, oversampled in the sys_clk domain.
module alpharetz_spi_peripheral
  import alpharetz_spi_pkg::*;
#(
  parameter int unsigned               SYNC_STAGES = 2,
  parameter logic [SPI_DATA_WIDTH-1:0] TX_IDLE     = SPI_DATA_WIDTH'('hFF)
) (
  input  logic                      sys_clk,
  input  logic                      async_rst,
  input  logic                      p_clk,
  input  logic                      p_sel_n,
  input  logic                      copi,
  output logic                      cipo,
  output logic                      cipo_oe,
  input  logic [SPI_DATA_WIDTH-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [SPI_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      tx_underrun,
  output logic                      frame_abort,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(SPI_DATA_WIDTH + 1);

  logic [1:0] rst_pipe_q;
  logic       rst;

  // Reset asserts immediately, releases two sys_clk edges after async_rst drops.
  always_ff @(posedge sys_clk or posedge async_rst) begin
    if (async_rst) rst_pipe_q <= 2'b11;
    else           rst_pipe_q <= {rst_pipe_q[0], 1'b0};
  end
  assign rst = rst_pipe_q[1];

  logic sclk_s, sclk_rise, sclk_fall;
  logic sel_s, sel_rise, sel_fall;
  logic copi_s, copi_rise_unused, copi_fall_unused;

  alpharetz_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk(sys_clk), .rst(rst), .d(p_clk), .q(sclk_s), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  // Chip select is active low: its falling edge starts a frame.
  alpharetz_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
    .clk(sys_clk), .rst(rst), .d(p_sel_n), .q(sel_s), .rise_c(sel_rise), .fall_c(sel_fall)
  );

  alpharetz_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(sys_clk), .rst(rst), .d(copi), .q(copi_s), .rise_c(copi_rise_unused), .fall_c(copi_fall_unused)
  );

  spi_periph_state_t         state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SPI_DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [SPI_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                      load_pend_q, load_pend_d;
  logic                      tx_ready_q, tx_ready_d;
  logic                      cipo_q, cipo_d;
  logic                      cipo_oe_q, cipo_oe_d;
  logic                      busy_q, busy_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      tx_underrun_q, tx_underrun_d;
  logic                      frame_abort_q, frame_abort_d;
  logic                      do_load;

  // State and datapath registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      shadow_q      <= '0;
      rx_data_q     <= '0;
      load_pend_q   <= 1'b0;
      tx_ready_q    <= 1'b1;
      cipo_q        <= 1'b0;
      cipo_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      shadow_q      <= shadow_d;
      rx_data_q     <= rx_data_d;
      load_pend_q   <= load_pend_d;
      tx_ready_q    <= tx_ready_d;
      cipo_q        <= cipo_d;
      cipo_oe_q     <= cipo_oe_d;
      busy_q        <= busy_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  // Next-state, shift datapath, shadow handshake and word load.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    shadow_d      = shadow_q;
    rx_data_d     = rx_data_q;
    load_pend_d   = load_pend_q;
    tx_ready_d    = tx_ready_q;
    cipo_d        = cipo_q;
    cipo_oe_d     = cipo_oe_q;
    busy_d        = busy_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    do_load       = 1'b0;

    if (tx_valid && tx_ready_q) begin
      shadow_d   = tx_data;
      tx_ready_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sel_fall) begin
          state_d     = SHIFT;
          busy_d      = 1'b1;
          cipo_oe_d   = 1'b1;
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
          do_load     = 1'b1;
        end
      end
      SHIFT: begin
        // Deselect outranks any p_clk edge seen in the same cycle.
        if (sel_rise) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          cipo_oe_d   = 1'b0;
          cipo_d      = 1'b0;
          load_pend_d = 1'b0;
          if (bit_cnt_q != '0) begin
            frame_abort_d = 1'b1;
            bit_cnt_d     = '0;
          end
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[SPI_DATA_WIDTH-2:0], copi_s};
          if (bit_cnt_q == CNT_W'(SPI_DATA_WIDTH - 1)) begin
            rx_data_d   = rx_shift_d;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            load_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (load_pend_q) begin
            do_load     = 1'b1;
            load_pend_d = 1'b0;
          end else if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[SPI_DATA_WIDTH-2:0], 1'b0};
            cipo_d     = tx_shift_q[SPI_DATA_WIDTH-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A word arriving in the load cycle bypasses the empty shadow.
    if (do_load) begin
      if (!tx_ready_q) begin
        tx_shift_d = shadow_q;
        tx_ready_d = 1'b1;
      end else if (tx_valid) begin
        tx_shift_d = tx_data;
        shadow_d   = shadow_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d    = TX_IDLE;
        tx_underrun_d = 1'b1;
      end
      cipo_d = tx_shift_d[SPI_DATA_WIDTH-1];
    end
  end

  assign cipo        = cipo_q;
  assign cipo_oe     = cipo_oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alpharetz_spi_peripheral.sv
// Directed bench for the SPI peripheral acting as a mode-0 controller at sys_clk/8.
module tb_alpharetz_spi_peripheral;

  logic       sys_clk = 1'b0;
  logic       async_rst;
  logic       p_clk;
  logic       p_sel_n;
  logic       copi;
  logic       cipo;
  logic       cipo_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       frame_abort;
  logic       busy;

  int tests_run = 0;
  int fails     = 0;
  int rx_pulses = 0;
  int und_pulses = 0;
  int abort_pulses = 0;
  logic [7:0] rx_log [0:7];

  alpharetz_spi_peripheral dut (
    .sys_clk(sys_clk), .async_rst(async_rst), .p_clk(p_clk), .p_sel_n(p_sel_n),
    .copi(copi), .cipo(cipo), .cipo_oe(cipo_oe), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse monitors sampled on the inactive edge.
  always @(negedge sys_clk) begin
    if (rx_valid) begin
      rx_log[rx_pulses[2:0]] = rx_data;
      rx_pulses++;
    end
    if (tx_underrun) und_pulses++;
    if (frame_abort) abort_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic push_tx(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (tx_ready) ok = 1'b1;
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL push_tx: tx_ready never high, word %h not accepted", d);
    end
  endtask

  task automatic start_frame();
    p_clk   = 1'b0;
    p_sel_n = 1'b0;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic end_frame();
    p_clk   = 1'b0;
    p_sel_n = 1'b1;
    repeat (8) @(negedge sys_clk);
  endtask

  // Controller side: drive copi while p_clk is low, sample cipo just before the rise.
  task automatic xfer(input logic [7:0] word, input int nbits, output logic [7:0] got);
    logic [2:0] idx;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      idx   = 3'(7 - i);
      p_clk = 1'b0;
      copi  = word[idx];
      repeat (4) @(negedge sys_clk);
      got[idx] = cipo;
      p_clk    = 1'b1;
      repeat (4) @(negedge sys_clk);
    end
  endtask

  task automatic test_reset();
    async_rst = 1'b1;
    p_clk = 1'b0; p_sel_n = 1'b1; copi = 1'b0; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    tests_run++; if (cipo !== 1'b0)     begin fails++; $display("FAIL reset_cipo: got %b want 0", cipo); end
    tests_run++; if (cipo_oe !== 1'b0)  begin fails++; $display("FAIL reset_cipo_oe: got %b want 0", cipo_oe); end
    tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    tests_run++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    tests_run++; if ({rx_valid, tx_underrun, frame_abort, busy} !== 4'b0000)
      begin fails++; $display("FAIL reset_pulses: got %b want 0000", {rx_valid, tx_underrun, frame_abort, busy}); end
    async_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_single_word();
    logic [7:0] got;
    int r0, u0;
    push_tx(8'hA5);
    tests_run++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL single_shadow_full: tx_ready got %b want 0", tx_ready); end
    r0 = rx_pulses; u0 = und_pulses;
    start_frame();
    tests_run++; if ({busy, cipo_oe} !== 2'b11) begin fails++; $display("FAIL single_busy_oe: got %b want 11", {busy, cipo_oe}); end
    xfer(8'h3C, 8, got);
    end_frame();
    tests_run++; if (got !== 8'hA5)    begin fails++; $display("FAIL single_cipo: got %h want a5", got); end
    tests_run++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL single_rx_data: got %h want 3c", rx_data); end
    tests_run++; if (rx_pulses - r0 !== 1) begin fails++; $display("FAIL single_rx_valid_count: got %0d want 1", rx_pulses - r0); end
    tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL single_tx_ready: got %b want 1", tx_ready); end
    tests_run++; if (und_pulses - u0 !== 0) begin fails++; $display("FAIL single_underrun: got %0d want 0", und_pulses - u0); end
    tests_run++; if ({busy, cipo_oe} !== 2'b00) begin fails++; $display("FAIL single_idle: got %b want 00", {busy, cipo_oe}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got1, got2;
    logic [2:0] i0, i1;
    int r0, u0;
    push_tx(8'h12);
    start_frame();
    push_tx(8'h34);
    r0 = rx_pulses; u0 = und_pulses;
    i0 = r0[2:0]; i1 = i0 + 3'd1;
    xfer(8'hF0, 8, got1);
    xfer(8'h0F, 8, got2);
    end_frame();
    tests_run++; if (got1 !== 8'h12) begin fails++; $display("FAIL b2b_cipo_word1: got %h want 12", got1); end
    tests_run++; if (got2 !== 8'h34) begin fails++; $display("FAIL b2b_cipo_word2: got %h want 34", got2); end
    tests_run++; if (rx_pulses - r0 !== 2) begin fails++; $display("FAIL b2b_rx_count: got %0d want 2", rx_pulses - r0); end
    tests_run++; if (rx_log[i0] !== 8'hF0) begin fails++; $display("FAIL b2b_rx_word1: got %h want f0", rx_log[i0]); end
    tests_run++; if (rx_log[i1] !== 8'h0F) begin fails++; $display("FAIL b2b_rx_word2: got %h want 0f", rx_log[i1]); end
    tests_run++; if (und_pulses - u0 !== 0) begin fails++; $display("FAIL b2b_underrun: got %0d want 0", und_pulses - u0); end
  endtask

  task automatic test_underrun();
    logic [7:0] got;
    int u0;
    u0 = und_pulses;
    start_frame();
    tests_run++; if (und_pulses - u0 !== 1) begin fails++; $display("FAIL underrun_at_sel: got %0d want 1", und_pulses - u0); end
    xfer(8'h55, 8, got);
    end_frame();
    tests_run++; if (got !== 8'hFF)      begin fails++; $display("FAIL underrun_cipo: got %h want ff", got); end
    tests_run++; if (und_pulses - u0 !== 1) begin fails++; $display("FAIL underrun_count: got %0d want 1", und_pulses - u0); end
    tests_run++; if (rx_data !== 8'h55)  begin fails++; $display("FAIL underrun_rx_data: got %h want 55", rx_data); end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    int r0, a0;
    r0 = rx_pulses; a0 = abort_pulses;
    start_frame();
    xfer(8'hAA, 5, got);
    end_frame();
    tests_run++; if (abort_pulses - a0 !== 1) begin fails++; $display("FAIL abort_count: got %0d want 1", abort_pulses - a0); end
    tests_run++; if (rx_pulses - r0 !== 0) begin fails++; $display("FAIL abort_rx_valid: got %0d want 0", rx_pulses - r0); end
    tests_run++; if (rx_data !== 8'h55)  begin fails++; $display("FAIL abort_rx_data_kept: got %h want 55", rx_data); end
    r0 = rx_pulses; a0 = abort_pulses;
    start_frame();
    xfer(8'h81, 8, got);
    end_frame();
    tests_run++; if (rx_data !== 8'h81)  begin fails++; $display("FAIL abort_next_rx: got %h want 81", rx_data); end
    tests_run++; if (rx_pulses - r0 !== 1) begin fails++; $display("FAIL abort_next_count: got %0d want 1", rx_pulses - r0); end
    tests_run++; if (abort_pulses - a0 !== 0) begin fails++; $display("FAIL abort_next_clean: got %0d want 0", abort_pulses - a0); end
  endtask

  task automatic test_collision();
    logic [7:0] got;
    int u0;
    u0 = und_pulses;
    p_clk   = 1'b0;
    p_sel_n = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge sys_clk);
    tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL collide_tx_ready: got %b want 1", tx_ready); end
    xfer(8'hE7, 8, got);
    end_frame();
    tests_run++; if (got !== 8'hC3)      begin fails++; $display("FAIL collide_cipo: got %h want c3", got); end
    tests_run++; if (und_pulses - u0 !== 0) begin fails++; $display("FAIL collide_underrun: got %0d want 0", und_pulses - u0); end
    tests_run++; if (rx_data !== 8'hE7)  begin fails++; $display("FAIL collide_rx_data: got %h want e7", rx_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    int u0;
    push_tx(8'h5A);
    start_frame();
    push_tx(8'h99);
    xfer(8'h0F, 3, got);
    #2 async_rst = 1'b1;
    #1;
    tests_run++; if ({busy, cipo_oe, cipo} !== 3'b000) begin fails++; $display("FAIL midrst_outputs: got %b want 000", {busy, cipo_oe, cipo}); end
    tests_run++; if (tx_ready !== 1'b1)  begin fails++; $display("FAIL midrst_tx_ready: got %b want 1", tx_ready); end
    tests_run++; if (rx_data !== 8'h00)  begin fails++; $display("FAIL midrst_rx_data: got %h want 00", rx_data); end
    p_clk   = 1'b0;
    p_sel_n = 1'b1;
    @(negedge sys_clk);
    async_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    u0 = und_pulses;
    start_frame();
    xfer(8'h24, 8, got);
    end_frame();
    tests_run++; if (got !== 8'hFF)      begin fails++; $display("FAIL midrst_shadow_lost: got %h want ff", got); end
    tests_run++; if (und_pulses - u0 !== 1) begin fails++; $display("FAIL midrst_underrun: got %0d want 1", und_pulses - u0); end
    tests_run++; if (rx_data !== 8'h24)  begin fails++; $display("FAIL midrst_rx_data_after: got %h want 24", rx_data); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_collision();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
